// File: rtl/fb_scanout_reader.sv
// rtl/fb_scanout_reader.sv - double-buffered framebuffer scanout: timing, read addressing, latency alignment.
// Optional SCANOUT_TEST_PATTERN_EN adds a test_pat input that overrides active pixels with colour bars.
module fb_scanout_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 20,
  parameter int FB_WORDS = 307200,
  parameter int RD_LAT   = 1
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [23:0]       rd_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic              test_pat,
`endif
  output logic [9:0]        o_sx,
  output logic [9:0]        o_sy,
  output logic              o_de,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [7:0]        o_r,
  output logic [7:0]        o_g,
  output logic [7:0]        o_b,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SBEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SEND = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SBEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SEND = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] FB_OFS = ADDR_W'(FB_WORDS);

  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [ADDR_W-2:0] pix_cnt_q, pix_cnt_d;
  logic              front_sel_q, front_sel_d;
  logic              swap_ack_q, swap_ack_d;
  logic              active, hsync_n, vsync_n, line_end, frame_wrap;

  always_comb begin
    active     = (sx_q < H_ACT) && (sy_q < V_ACT);
    hsync_n    = !((sx_q >= H_SBEG) && (sx_q < H_SEND));
    vsync_n    = !((sy_q >= V_SBEG) && (sy_q < V_SEND));
    line_end   = (sx_q == H_LAST);
    frame_wrap = line_end && (sy_q == V_LAST);
    sx_d       = line_end ? 10'd0 : sx_q + 10'd1;
    sy_d       = sy_q;
    if (line_end) sy_d = (sy_q == V_LAST) ? 10'd0 : sy_q + 10'd1;
    pix_cnt_d  = pix_cnt_q;
    if (frame_wrap)  pix_cnt_d = '0;
    else if (active) pix_cnt_d = pix_cnt_q + 1'b1;
    // Swap requests are only honoured on the frame-wrap cycle so a frame never tears.
    swap_ack_d  = frame_wrap && swap_req;
    front_sel_d = front_sel_q ^ swap_ack_d;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      pix_cnt_q   <= '0;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      pix_cnt_q   <= pix_cnt_d;
      front_sel_q <= front_sel_d;
      swap_ack_q  <= swap_ack_d;
    end
  end

  assign rd_addr   = {1'b0, pix_cnt_q} + (front_sel_q ? FB_OFS : '0);
  assign rd_en     = active;
  assign swap_ack  = swap_ack_q;
  assign front_sel = front_sel_q;

  // Timing side-band delayed to match the RAM read latency.
  logic [RD_LAT-1:0][9:0] sx_p_q, sy_p_q;
  logic [RD_LAT-1:0]      de_p_q, hs_p_q, vs_p_q, fs_p_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_p_q <= '0;
      sy_p_q <= '0;
      de_p_q <= '0;
      hs_p_q <= '1;
      vs_p_q <= '1;
      fs_p_q <= '0;
    end else begin
      sx_p_q[0] <= sx_q;
      sy_p_q[0] <= sy_q;
      de_p_q[0] <= active;
      hs_p_q[0] <= hsync_n;
      vs_p_q[0] <= vsync_n;
      fs_p_q[0] <= (sx_q == 10'd0) && (sy_q == 10'd0);
      for (int k = RD_LAT - 1; k > 0; k--) begin
        sx_p_q[k] <= sx_p_q[k-1];
        sy_p_q[k] <= sy_p_q[k-1];
        de_p_q[k] <= de_p_q[k-1];
        hs_p_q[k] <= hs_p_q[k-1];
        vs_p_q[k] <= vs_p_q[k-1];
        fs_p_q[k] <= fs_p_q[k-1];
      end
    end
  end

  logic [23:0] rgb_d, rgb_q;
  logic        de_dly;

`ifdef SCANOUT_TEST_PATTERN_EN
  logic [2:0] bar;
  always_comb begin
    de_dly = de_p_q[RD_LAT-1];
    bar    = 3'(sx_p_q[RD_LAT-1] / 10'd80);
    rgb_d  = de_dly ? rd_data : 24'd0;
    if (test_pat && de_dly)
      rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
  end
`else
  always_comb begin
    de_dly = de_p_q[RD_LAT-1];
    rgb_d  = de_dly ? rd_data : 24'd0;
  end
`endif

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      o_sx        <= '0;
      o_sy        <= '0;
      o_de        <= 1'b0;
      o_hsync     <= 1'b1;
      o_vsync     <= 1'b1;
      rgb_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      o_sx        <= sx_p_q[RD_LAT-1];
      o_sy        <= sy_p_q[RD_LAT-1];
      o_de        <= de_dly;
      o_hsync     <= hs_p_q[RD_LAT-1];
      o_vsync     <= vs_p_q[RD_LAT-1];
      rgb_q       <= rgb_d;
      frame_start <= fs_p_q[RD_LAT-1];
    end
  end

  assign o_r = rgb_q[23:16];
  assign o_g = rgb_q[15:8];
  assign o_b = rgb_q[7:0];

endmodule
